// File: rtl/alu_seq.sv
// Registered ALU with a persistent status register and an iterative shift-add multiplier.
// Latency: single-cycle ops 1 cycle; MUL WIDTH+1 cycles from accept to next accept. in_ready drops only while a multiply iterates.
// Backpressure: in_valid is ignored while in_ready is low, so the source must hold the request.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [4:0]       psr,
    input  logic             psr_we,
    input  logic [4:0]       psr_wdata,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] SH_LIMIT = (WIDTH + 1)'(WIDTH);

    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_ADDU = 8'd1;
    localparam logic [7:0] OP_ADDC = 8'd2;
    localparam logic [7:0] OP_SUB  = 8'd3;
    localparam logic [7:0] OP_CMP  = 8'd4;
    localparam logic [7:0] OP_CMPU = 8'd5;
    localparam logic [7:0] OP_AND  = 8'd6;
    localparam logic [7:0] OP_OR   = 8'd7;
    localparam logic [7:0] OP_XOR  = 8'd8;
    localparam logic [7:0] OP_NOT  = 8'd9;
    localparam logic [7:0] OP_LSH  = 8'd10;
    localparam logic [7:0] OP_ASH  = 8'd11;
    localparam logic [7:0] OP_MUL  = 8'd12;
    localparam logic [7:0] OP_MOV  = 8'd13;

    typedef enum logic {S_IDLE, S_MULT} state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             illegal_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       psr_q;
    logic [WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic [WIDTH-1:0] mul_acc_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] result_d;
    logic [4:0]       psr_d;
    logic             legal_d;
    logic             set_z;
    logic             set_n;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   adc_full;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] sub_res;
    logic             sh_neg;
    logic [WIDTH:0]   sh_mag;
    logic             sh_big;
    logic [WIDTH-1:0] lsh_res;
    logic [WIDTH-1:0] asr_res;
    logic [WIDTH-1:0] ash_res;
    logic [WIDTH-1:0] mul_acc_d;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign adc_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, psr_q[PSR_C]};
    assign neg_b    = ~b + 1'b1;
    assign sub_res  = a + neg_b;

    // Shift amount is two's complement; the magnitude needs one extra bit for the most negative value.
    assign sh_neg   = b[MSB];
    assign sh_mag   = sh_neg ? ({1'b0, ~b} + 1'b1) : {1'b0, b};
    assign sh_big   = (sh_mag >= SH_LIMIT);
    assign asr_res  = $signed(a) >>> sh_mag;
    assign lsh_res  = sh_big ? '0 : (sh_neg ? (a >> sh_mag) : (a << sh_mag));
    assign ash_res  = !sh_neg ? lsh_res : (sh_big ? {WIDTH{a[MSB]}} : asr_res);

    assign mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

    always_comb begin
        result_d = result_q;
        psr_d    = psr_q;
        legal_d  = 1'b1;
        set_z    = 1'b0;
        set_n    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result_d     = add_full[MSB:0];
                psr_d[PSR_F] = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
                set_z        = 1'b1;
                set_n        = 1'b1;
            end
            OP_ADDU: begin
                result_d     = add_full[MSB:0];
                psr_d[PSR_C] = add_full[WIDTH];
                set_z        = 1'b1;
            end
            OP_ADDC: begin
                result_d     = adc_full[MSB:0];
                psr_d[PSR_C] = adc_full[WIDTH];
                set_z        = 1'b1;
            end
            OP_SUB: begin
                result_d     = sub_res;
                psr_d[PSR_C] = (a < b);
                psr_d[PSR_F] = (a[MSB] == neg_b[MSB]) && (sub_res[MSB] != a[MSB]);
                set_z        = 1'b1;
                set_n        = 1'b1;
            end
            OP_CMP: begin
                psr_d[PSR_N] = ($signed(a) < $signed(b));
                psr_d[PSR_Z] = (a == b);
            end
            OP_CMPU: begin
                psr_d[PSR_L] = (a < b);
                psr_d[PSR_Z] = (a == b);
            end
            OP_AND: begin result_d = a & b; set_z = 1'b1; set_n = 1'b1; end
            OP_OR:  begin result_d = a | b; set_z = 1'b1; set_n = 1'b1; end
            OP_XOR: begin result_d = a ^ b; set_z = 1'b1; set_n = 1'b1; end
            OP_NOT: begin result_d = ~a;    set_z = 1'b1; set_n = 1'b1; end
            OP_LSH: begin result_d = lsh_res; set_z = 1'b1; end
            OP_ASH: begin result_d = ash_res; set_z = 1'b1; set_n = 1'b1; end
            OP_MUL: ;
            OP_MOV: result_d = b;
            default: legal_d = 1'b0;
        endcase
        if (set_z) psr_d[PSR_Z] = ~|result_d;
        if (set_n) psr_d[PSR_N] = result_d[MSB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            result_q    <= '0;
            psr_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_acc_q   <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        if (opcode == OP_MUL) begin
                            mul_a_q    <= a;
                            mul_b_q    <= b;
                            mul_acc_q  <= '0;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= S_MULT;
                        end else begin
                            result_q    <= result_d;
                            psr_q       <= psr_d;
                            out_valid_q <= 1'b1;
                            illegal_q   <= ~legal_d;
                        end
                    end
                end
                S_MULT: begin
                    mul_acc_q <= mul_acc_d;
                    mul_a_q   <= mul_a_q << 1;
                    mul_b_q   <= mul_b_q >> 1;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_q     <= mul_acc_d;
                        psr_q[PSR_Z] <= ~|mul_acc_d;
                        psr_q[PSR_N] <= mul_acc_d[MSB];
                        out_valid_q  <= 1'b1;
                        in_ready_q   <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // A context restore overrides every flag a coinciding completion would have written.
            if (psr_we) psr_q <= psr_wdata;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign result    = result_q;
    assign psr       = psr_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random stimulus for alu_seq, checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 16;
    localparam longint MASK = 64'hFFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    opcode = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  result;
    logic          out_valid;
    logic [4:0]    psr;
    logic          psr_we = 1'b0;
    logic [4:0]    psr_wdata = '0;
    logic          illegal;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .result(result), .out_valid(out_valid),
        .psr(psr), .psr_we(psr_we), .psr_wdata(psr_wdata), .illegal(illegal)
    );

    int nchk = 0;
    int npass = 0;

    longint mres = 0;
    bit mC = 0, mL = 0, mF = 0, mZ = 0, mN = 0;

    function automatic logic [4:0] mpsr();
        return {mC, mL, mF, mZ, mN};
    endfunction

    function automatic bit msb(input longint x);
        return bit'((x >> 15) & 1);
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
    endtask

    // Reference semantics straight from the opcode table, using plain integer arithmetic.
    task automatic model(input logic [7:0] op, input logic [15:0] ta, input logic [15:0] tb, output bit legal);
        longint ua, ub, sa, sb, r, nb, k;
        ua = longint'(ta);
        ub = longint'(tb);
        sa = longint'($signed(ta));
        sb = longint'($signed(tb));
        r = mres;
        legal = 1;
        case (op)
            0: begin r = (ua + ub) & MASK; mF = (msb(ua) == msb(ub)) && (msb(r) != msb(ua)); mZ = (r == 0); mN = msb(r); end
            1: begin r = (ua + ub) & MASK; mC = (ua + ub) > MASK; mZ = (r == 0); end
            2: begin r = (ua + ub + longint'(mC)) & MASK; mC = (ua + ub + longint'(mC)) > MASK; mZ = (r == 0); end
            3: begin
                nb = (-ub) & MASK;
                r = (ua - ub) & MASK;
                mC = ua < ub;
                mF = (msb(ua) == msb(nb)) && (msb(r) != msb(ua));
                mZ = (r == 0); mN = msb(r);
            end
            4: begin mN = sa < sb; mZ = (ua == ub); end
            5: begin mL = ua < ub; mZ = (ua == ub); end
            6: begin r = ua & ub; mZ = (r == 0); mN = msb(r); end
            7: begin r = ua | ub; mZ = (r == 0); mN = msb(r); end
            8: begin r = ua ^ ub; mZ = (r == 0); mN = msb(r); end
            9: begin r = (~ua) & MASK; mZ = (r == 0); mN = msb(r); end
            10, 11: begin
                if (sb >= 0) begin
                    r = (sb >= W) ? 0 : ((ua << sb) & MASK);
                end else begin
                    k = -sb;
                    if (op == 10) r = (k >= W) ? 0 : (ua >> k);
                    else begin
                        if (k > W) k = W;
                        r = (sa >>> k) & MASK;
                    end
                end
                mZ = (r == 0);
                if (op == 11) mN = msb(r);
            end
            12: begin r = (ua * ub) & MASK; mZ = (r == 0); mN = msb(r); end
            13: r = ub;
            default: legal = 0;
        endcase
        mres = r;
    endtask

    task automatic step_op(input string tag, input logic [7:0] op, input logic [15:0] ta, input logic [15:0] tb,
                           input logic we, input logic [4:0] wd);
        bit legal;
        opcode = op; a = ta; b = tb; psr_we = we; psr_wdata = wd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; psr_we = 1'b0;
        model(op, ta, tb, legal);
        if (we) {mC, mL, mF, mZ, mN} = wd;
        chk(tag, "result", 32'(result), 32'(mres));
        chk(tag, "psr", 32'(psr), 32'(mpsr()));
        chk(tag, "out_valid", 32'(out_valid), 32'd1);
        chk(tag, "illegal", 32'(illegal), 32'(!legal));
        chk(tag, "in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb);
        int n;
        bit ready_hi;
        bit legal;
        opcode = 8'd12; a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(tag, "busy_ready", 32'(in_ready), 32'd0);
        n = 0;
        ready_hi = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!out_valid && in_ready) ready_hi = 1;
        end
        model(8'd12, ta, tb, legal);
        chk(tag, "cycles", 32'(n), 32'd16);
        chk(tag, "ready_low", 32'(ready_hi), 32'd0);
        chk(tag, "result", 32'(result), 32'(mres));
        chk(tag, "psr", 32'(psr), 32'(mpsr()));
        chk(tag, "illegal", 32'(illegal), 32'(!legal));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit legal;
        bit seen_ov;
        int sel;
        int sh;
        logic [7:0] rop;
        logic [15:0] ra, rb;
        logic rwe;
        logic [4:0] rwd;

        repeat (3) @(posedge clk);
        #1;
        chk("reset", "result", 32'(result), 32'd0);
        chk("reset", "psr", 32'(psr), 32'd0);
        chk("reset", "in_ready", 32'(in_ready), 32'd1);
        chk("reset", "out_valid", 32'(out_valid), 32'd0);
        chk("reset", "illegal", 32'(illegal), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        step_op("add_ovf", 8'd0, 16'h7FFF, 16'h0001, 1'b0, 5'h0);
        @(posedge clk); #1;
        chk("add_ovf", "pulse_end", 32'(out_valid), 32'd0);

        step_op("addu", 8'd1, 16'hFFFF, 16'h0001, 1'b0, 5'h0);
        step_op("addc", 8'd2, 16'h0001, 16'h0001, 1'b0, 5'h0);
        step_op("cmp", 8'd4, 16'hFFFF, 16'h0001, 1'b0, 5'h0);
        step_op("cmpu", 8'd5, 16'hFFFF, 16'h0001, 1'b0, 5'h0);
        step_op("sub", 8'd3, 16'h0003, 16'h0005, 1'b0, 5'h0);
        step_op("lsh_r1", 8'd10, 16'h8001, 16'hFFFF, 1'b0, 5'h0);
        step_op("ash_r20", 8'd11, 16'h8000, 16'hFFEC, 1'b0, 5'h0);
        step_op("lsh_l16", 8'd10, 16'h0001, 16'h0010, 1'b0, 5'h0);
        step_op("ash_min", 8'd11, 16'h4000, 16'h8000, 1'b0, 5'h0);
        step_op("illegal", 8'hAA, 16'h1234, 16'h5678, 1'b0, 5'h0);
        step_op("psr_we_add", 8'd0, 16'h1234, 16'h0001, 1'b1, 5'h15);

        psr_we = 1'b1; psr_wdata = 5'h0A;
        @(posedge clk); #1;
        psr_we = 1'b0;
        {mC, mL, mF, mZ, mN} = 5'h0A;
        chk("psr_we_only", "psr", 32'(psr), 32'h0A);
        chk("psr_we_only", "out_valid", 32'(out_valid), 32'd0);

        do_mul("mul", 16'h0123, 16'h0045);

        // A request held valid through a multiply must be taken the cycle after completion.
        opcode = 8'd12; a = 16'h00FF; b = 16'h0101; in_valid = 1'b1;
        @(posedge clk); #1;
        opcode = 8'd0; a = 16'h0001; b = 16'h0002;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        model(8'd12, 16'h00FF, 16'h0101, legal);
        chk("mul_held", "cycles", 32'(n), 32'd16);
        chk("mul_held", "result", 32'(result), 32'(mres));
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(8'd0, 16'h0001, 16'h0002, legal);
        chk("held_add", "result", 32'(result), 32'(mres));
        chk("held_add", "out_valid", 32'(out_valid), 32'd1);
        chk("held_add", "psr", 32'(psr), 32'(mpsr()));

        opcode = 8'd12; a = 16'h0123; b = 16'h0045; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen_ov = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen_ov = 1;
        end
        rst_n = 1'b0;
        #2;
        mres = 0;
        {mC, mL, mF, mZ, mN} = 5'h0;
        chk("mul_abort", "result", 32'(result), 32'd0);
        chk("mul_abort", "psr", 32'(psr), 32'd0);
        chk("mul_abort", "in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen_ov = 1;
        end
        chk("mul_abort", "no_out_valid", 32'(seen_ov), 32'd0);
        chk("mul_abort", "result_after", 32'(result), 32'd0);

        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (sel >= 14) rop = 8'($urandom_range(14, 255));
            else rop = 8'(sel);
            if ((rop == 8'd10 || rop == 8'd11) && $urandom_range(0, 1) == 1) begin
                sh = int'($urandom_range(0, 40)) - 20;
                rb = sh[15:0];
            end
            rwe = ($urandom_range(0, 7) == 0);
            rwd = 5'($urandom);
            if (rop == 8'd12) do_mul("rnd_mul", ra, rb);
            else step_op("rnd", rop, ra, rb, rwe, rwd);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
